serial_alu_ctrl: RTL and testbench



---
 rtl/serial_alu_ctrl.sv | 171 +++++++++++++++++
 tb/tb_serial_alu_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU sequencer.
// Runs a WIDTH-bit AND/OR/ADD/SUB/SLT one bit per clock through an external
// 1-bit ALU slice, LSB first, behind a start/busy/done handshake.
// Optional build macro SERIAL_ALU_FLAGS_EN adds registered zero/ovf flag outputs.
module serial_alu_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_invertB,
    output logic [1:0]       slice_signal,
    output logic             slice_less,
    input  logic             slice_out,
    input  logic             slice_cout
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_sr, b_sr;
    logic [2:0]         op_q;
    logic [CNT_W-1:0]   cnt;
    logic               carry;

    logic               run;
    logic               last_bit;
    logic               is_sub;
    logic               is_arith;
    logic               less;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   final_result;

    assign run      = (state == S_RUN);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign is_arith = (op_q == OP_ADD) || is_sub;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign slice_less = 1'b0;

    // Signed less-than from the MSB stage: sum sign corrected by overflow.
    assign less    = slice_out ^ (carry ^ slice_cout);
    assign shifted = {slice_out, result[WIDTH-1:1]};

    // Value written into result on the final RUN edge, selected by the latched op.
    always_comb begin
        final_result = '0;
        case (op_q)
            OP_AND, OP_OR, OP_ADD, OP_SUB: final_result = shifted;
            OP_SLT:                        final_result = {{(WIDTH-1){1'b0}}, less};
            default:                       final_result = '0;
        endcase
    end

    // Slice controls: driven only while RUN so the slice sees zeros otherwise.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        slice_a       = 1'b0;
        slice_b       = 1'b0;
        slice_cin     = 1'b0;
        slice_invertB = 1'b0;
        slice_signal  = 2'b00;
        if (run) begin
            slice_a       = a_sr[0];
            slice_b       = b_sr[0];
            slice_cin     = carry;
            slice_invertB = is_sub;
            if (is_arith)
                slice_signal = 2'b10;
            else if (op_q == OP_OR)
                slice_signal = 2'b01;
            else
                slice_signal = 2'b00;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: start is honoured only in IDLE; DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_bit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, per-bit shifting and final result write.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            op_q   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= opA;
                        b_sr  <= opB;
                        op_q  <= op;
                        cnt   <= '0;
                        carry <= (op == OP_SUB) || (op == OP_SLT);
                    end
                end
                S_RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= slice_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit)
                        result <= final_result;
                    else
                        result <= shifted;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    // Flags registered alongside result on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (run && last_bit) begin
            zero <= (final_result == '0);
            ovf  <= ((op_q == OP_ADD) || (op_q == OP_SUB)) && (carry ^ slice_cout);
        end
    end
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: scoreboard bench for serial_alu_ctrl (WIDTH=8) with a
// behavioural 1-bit ALU slice. Honours SERIAL_ALU_FLAGS_EN when defined.
module tb_serial_alu_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opA, opB;
    logic             busy, done;
    logic [WIDTH-1:0] result;
    logic             slice_a, slice_b, slice_cin, slice_invertB, slice_less;
    logic [1:0]       slice_signal;
    logic             slice_out, slice_cout;
`ifdef SERIAL_ALU_FLAGS_EN
    logic             zero, ovf;
`endif

    serial_alu_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
        .busy(busy), .done(done), .result(result),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_invertB(slice_invertB), .slice_signal(slice_signal),
        .slice_less(slice_less), .slice_out(slice_out), .slice_cout(slice_cout)
`ifdef SERIAL_ALU_FLAGS_EN
        , .zero(zero), .ovf(ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 1-bit ALU slice.
    logic b_eff;
    assign b_eff = slice_b ^ slice_invertB;
    always_comb begin
        slice_out = 1'b0;
        case (slice_signal)
            2'b00:   slice_out = slice_a & b_eff;
            2'b01:   slice_out = slice_a | b_eff;
            2'b10:   slice_out = slice_a ^ b_eff ^ slice_cin;
            default: slice_out = 1'b0;
        endcase
        slice_cout = (slice_a & b_eff) | (slice_a & slice_cin) | (b_eff & slice_cin);
    end

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ovf;
        int               done_cyc;
        string            name;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] cur_op = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on done and checks slice controls in RUN.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] sig;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_result"}, 32'(result), 32'(e.res));
                check({e.name, "_latency"}, 32'(cyc), 32'(e.done_cyc));
`ifdef SERIAL_ALU_FLAGS_EN
                check({e.name, "_zero"}, 32'(zero), 32'(e.zero));
                check({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
            end
        end
        if (busy === 1'b1 && done === 1'b0) begin
            sig = (cur_op == 3'd2 || cur_op == 3'd3 || cur_op == 3'd4) ? 2'b10 :
                  (cur_op == 3'd1) ? 2'b01 : 2'b00;
            check("run_signal", 32'(slice_signal), 32'(sig));
            check("run_invertB", 32'(slice_invertB), 32'(cur_op == 3'd3 || cur_op == 3'd4));
            check("run_less", 32'(slice_less), 32'd0);
        end
    end

    int n0;

    task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] r, input logic z, input logic v,
                         input string name, input bit push);
        exp_t e;
        int g = 0;
        @(negedge clk);
        while (busy !== 1'b0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        start = 1'b1; op = o; opA = a; opB = b;
        cur_op = o;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n0 = cyc;
        if (push) begin
            e.res = r; e.zero = z; e.ovf = v; e.done_cyc = n0 + WIDTH; e.name = name;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; opA = '0; opB = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_slice", 32'({slice_a, slice_b, slice_cin, slice_invertB, slice_signal, slice_less}), 32'd0);
        rst = 1'b0;

        // ADD 7F+01 with exact busy/done timing.
        issue(3'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "add_7f_01", 1'b1);
        for (int j = 0; j <= WIDTH + 1; j++) begin
            check("add_busy", 32'(busy), 32'(j <= WIDTH));
            check("add_done", 32'(done), 32'(j == WIDTH));
            @(negedge clk);
        end
        wait_drain();

        issue(3'd3, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, "sub_05_07", 1'b1); wait_drain();
        issue(3'd3, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, "sub_33_33", 1'b1); wait_drain();
        issue(3'd4, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, "slt_80_01", 1'b1); wait_drain();
        issue(3'd4, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, "slt_01_80", 1'b1); wait_drain();
        issue(3'd4, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, "slt_ff_ff", 1'b1); wait_drain();
        issue(3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, "and_f0_3c", 1'b1); wait_drain();
        issue(3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, "or_f0_3c", 1'b1); wait_drain();

        // Start pulsed while busy must be ignored.
        issue(3'd2, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, "add_ignore", 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1; op = 3'd0; opA = 8'hFF; opB = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Reset mid-operation abandons it with no done pulse.
        issue(3'd2, 8'h55, 8'h0F, 8'h00, 1'b0, 1'b0, "add_abort", 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_slice", 32'({slice_a, slice_b, slice_cin, slice_invertB, slice_signal}), 32'd0);
        repeat (WIDTH + 4) @(negedge clk);
        issue(3'd2, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, "add_after_rst", 1'b1); wait_drain();

        // Reserved op keeps full latency and yields zero.
        issue(3'd6, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, "reserved_6", 1'b1); wait_drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
